// File: rtl/fruit_icon_overlay.sv
// Overlays a ROM-stored icon onto an RGB565 pixel stream at a fixed window,
// keeping syncs aligned with the ROM read latency and treating KEY_COLOR as transparent.
module fruit_icon_overlay #(
    parameter int                    H_START     = 0,
    parameter int                    V_START     = 0,
    parameter int                    IMG_W       = 64,
    parameter int                    IMG_H       = 64,
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ROM_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR   = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  overlay_en,
    input  logic                  in_vs,
    input  logic                  in_hs,
    input  logic                  in_de,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic                  out_vs,
    output logic                  out_hs,
    output logic                  out_de,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int CW = 16;
    localparam int PW = DATA_WIDTH + 4;
    localparam logic [CW-1:0]         X_LO     = CW'(H_START);
    localparam logic [CW-1:0]         X_HI     = CW'(H_START + IMG_W);
    localparam logic [CW-1:0]         Y_LO     = CW'(V_START);
    localparam logic [CW-1:0]         Y_HI     = CW'(V_START + IMG_H);
    localparam logic [CW-1:0]         CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_W);

    logic [1:0]            rst_sync_r;
    logic                  rst_int_n_s;
    logic                  vs_d_r;
    logic                  de_d_r;
    logic                  en_frame_r;
    logic [CW-1:0]         x_r;
    logic [CW-1:0]         y_r;
    logic [ADDR_WIDTH-1:0] row_base_r;

    logic                  vs_rise_s;
    logic                  de_fall_s;
    logic [CW-1:0]         x_s;
    logic [CW-1:0]         y_s;
    logic                  en_s;
    logic [ADDR_WIDTH-1:0] row_base_s;
    logic                  x_in_s;
    logic                  y_in_s;
    logic                  in_win_s;

    logic [PW-1:0]         pipe_r [ROM_LATENCY];
    logic [PW-1:0]         tap_s;
    logic                  tap_vs_s;
    logic                  tap_hs_s;
    logic                  tap_de_s;
    logic                  tap_win_s;
    logic [DATA_WIDTH-1:0] tap_data_s;
    logic [DATA_WIDTH-1:0] data_mux_s;

    // Reset synchronizer: asserts asynchronously, releases on the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_r[1];
    assign vs_rise_s   = in_vs & ~vs_d_r & rst_int_n_s;
    assign de_fall_s   = de_d_r & ~in_de;

    // Effective coordinates for this pixel; a frame-start pixel counts as x=0, y=0.
    always_comb begin
        x_s        = x_r;
        y_s        = y_r;
        en_s       = en_frame_r;
        row_base_s = row_base_r;
        if (vs_rise_s) begin
            x_s        = {CW{1'b0}};
            y_s        = {CW{1'b0}};
            en_s       = overlay_en;
            row_base_s = {ADDR_WIDTH{1'b0}};
        end else begin
            x_s        = x_r;
            y_s        = y_r;
            en_s       = en_frame_r;
            row_base_s = row_base_r;
        end
    end

    assign x_in_s   = (x_s >= X_LO) && (x_s < X_HI);
    assign y_in_s   = (y_s >= Y_LO) && (y_s < Y_HI);
    assign in_win_s = en_s & in_de & x_in_s & y_in_s;

    // ROM address follows row_base so clipped rows still start on their own row.
    always_comb begin
        rom_addr = row_base_s;
        if (in_win_s) begin
            rom_addr = row_base_s + ADDR_WIDTH'(x_s - X_LO);
        end else begin
            rom_addr = row_base_s;
        end
    end

    // Raster position, frame enable and row base tracking.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            vs_d_r     <= 1'b0;
            de_d_r     <= 1'b0;
            en_frame_r <= 1'b0;
            x_r        <= {CW{1'b0}};
            y_r        <= {CW{1'b0}};
            row_base_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            vs_d_r     <= in_vs;
            de_d_r     <= in_de;
            en_frame_r <= en_s;
            x_r        <= in_de ? (x_s + CNT_ONE) : {CW{1'b0}};
            if (vs_rise_s) begin
                y_r        <= {CW{1'b0}};
                row_base_r <= {ADDR_WIDTH{1'b0}};
            end else if (de_fall_s) begin
                y_r        <= y_r + CNT_ONE;
                row_base_r <= y_in_s ? (row_base_r + ROW_STEP) : row_base_r;
            end else begin
                y_r        <= y_r;
                row_base_r <= row_base_r;
            end
        end
    end

    // Delay line matching the ROM read latency.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                pipe_r[i] <= {PW{1'b0}};
            end
        end else begin
            pipe_r[0] <= {in_vs, in_hs, in_de, in_win_s, in_data};
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign tap_s      = pipe_r[ROM_LATENCY-1];
    assign tap_vs_s   = tap_s[PW-1];
    assign tap_hs_s   = tap_s[PW-2];
    assign tap_de_s   = tap_s[PW-3];
    assign tap_win_s  = tap_s[PW-4];
    assign tap_data_s = tap_s[DATA_WIDTH-1:0];

    // Composite: icon pixel unless transparent, blank outside active video.
    always_comb begin
        data_mux_s = tap_data_s;
        if (!tap_de_s) begin
            data_mux_s = {DATA_WIDTH{1'b0}};
        end else if (tap_win_s && (rom_rd_data != KEY_COLOR)) begin
            data_mux_s = rom_rd_data;
        end else begin
            data_mux_s = tap_data_s;
        end
    end

    // Output register, loaded every cycle.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            out_vs   <= 1'b0;
            out_hs   <= 1'b0;
            out_de   <= 1'b0;
            out_data <= {DATA_WIDTH{1'b0}};
        end else begin
            out_vs   <= tap_vs_s;
            out_hs   <= tap_hs_s;
            out_de   <= tap_de_s;
            out_data <= data_mux_s;
        end
    end

endmodule
